// File: rtl/pe_seq_ctrl.sv
// Job sequencer for a 4-lane, 3-stage PE MAC pipeline: admits operand beats, drives the PE stall,
// accumulates per-beat p_sum results and holds each job result in a valid/ready output register.
// Optional saturating accumulation is enabled by defining PE_SEQ_SAT_EN.
module pe_seq_ctrl #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_W-1:0]        job_len,
  output logic                    busy,
  input  logic                    op_valid,
  output logic                    op_ready,
  output logic                    pe_stall,
  input  logic signed [24:0]      pe_p_sum,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    acc_valid,
  input  logic                    acc_ready,
  output logic                    acc_ovf,
  output logic                    done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state, state_nxt;
  logic [LEN_W-1:0]        len_q, issued, retired;
  logic [2:0]              vld;
  logic signed [ACC_W-1:0] acc, acc_base, acc_nxt, p_ext;
  logic                    start_acc, fire, retire, last_pend, last_retire;

  assign busy      = (state == RUN);
  assign start_acc = (state == IDLE) && start && (job_len != '0);
  assign last_pend = (state == RUN) && vld[2] && (retired == len_q - LEN_W'(1));

  // A result waiting in a full output register blocks only the job's last retire,
  // and a same-cycle accept frees the slot for it.
  assign pe_stall    = (state == IDLE) || (last_pend && acc_valid && !acc_ready);
  assign op_ready    = (state == RUN) && (issued < len_q) && !pe_stall;
  assign fire        = op_valid && op_ready;
  assign retire      = vld[2] && !pe_stall;
  assign last_retire = retire && last_pend;

  // The first retire of a job loads rather than adds, so the old accumulator never leaks in.
  assign p_ext    = ACC_W'(pe_p_sum);
  assign acc_base = (retired == '0) ? '0 : acc;

`ifdef PE_SEQ_SAT_EN
  logic [ACC_W:0] sum_ext;
  logic           ovf_now, ovf_sticky, acc_ovf_q;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    acc_nxt = '0;
    sum_ext = {acc_base[ACC_W-1], acc_base} + {p_ext[ACC_W-1], p_ext};
    ovf_now = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    if (!ovf_now)
      acc_nxt = sum_ext[ACC_W-1:0];
    else if (sum_ext[ACC_W])
      acc_nxt = {1'b1, {(ACC_W-1){1'b0}}};
    else
      acc_nxt = {1'b0, {(ACC_W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      acc_ovf_q  <= 1'b0;
    end else begin
      if (start_acc)
        ovf_sticky <= 1'b0;
      else if (retire && ovf_now)
        ovf_sticky <= 1'b1;
      if (last_retire)
        acc_ovf_q <= ovf_sticky | ovf_now;
    end
  end

  assign acc_ovf = acc_ovf_q;
`else
  assign acc_nxt = acc_base + p_ext;
  assign acc_ovf = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_acc) state_nxt = RUN;
      RUN:     if (last_retire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      issued    <= '0;
      retired   <= '0;
      vld       <= '0;
      acc       <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
      state <= state_nxt;
      done  <= last_retire;

      if (start_acc) begin
        len_q   <= job_len;
        issued  <= '0;
        retired <= '0;
        acc     <= '0;
      end else begin
        if (fire)
          issued <= issued + LEN_W'(1);
        if (retire) begin
          acc     <= acc_nxt;
          retired <= retired + LEN_W'(1);
        end
      end

      // vld mirrors the PE pipeline, so it freezes exactly when the PE does.
      if (!pe_stall)
        vld <= {vld[1:0], fire};

      if (last_retire) begin
        acc_out   <= acc_nxt;
        acc_valid <= 1'b1;
      end else if (acc_valid && acc_ready) begin
        acc_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Self-checking bench for pe_seq_ctrl: behavioural 3-stage PE model, job table, scoreboard of results,
// plus hand-written timing, backpressure, wide-overflow and mid-job reset sequences.
module tb_pe_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [31:0]        ifm, wgt;

  logic               start, busy, op_valid, op_ready, pe_stall, acc_valid, acc_ready, acc_ovf, done;
  logic [7:0]         job_len;
  logic signed [24:0] pe_p_sum;
  logic signed [31:0] acc_out;

  logic               start_w, busy_w, op_valid_w, op_ready_w, pe_stall_w;
  logic               acc_valid_w, acc_ready_w, acc_ovf_w, done_w;
  logic [8:0]         job_len_w;
  logic signed [24:0] pe_p_sum_w;
  logic signed [24:0] acc_out_w;

  pe_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .job_len(job_len), .busy(busy),
    .op_valid(op_valid), .op_ready(op_ready), .pe_stall(pe_stall), .pe_p_sum(pe_p_sum),
    .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_ovf(acc_ovf), .done(done)
  );

  pe_seq_ctrl #(.LEN_W(9), .ACC_W(25)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .job_len(job_len_w), .busy(busy_w),
    .op_valid(op_valid_w), .op_ready(op_ready_w), .pe_stall(pe_stall_w), .pe_p_sum(pe_p_sum_w),
    .acc_out(acc_out_w), .acc_valid(acc_valid_w), .acc_ready(acc_ready_w), .acc_ovf(acc_ovf_w),
    .done(done_w)
  );

  function automatic logic signed [24:0] dot(input logic [31:0] a, input logic [31:0] w);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++)
      s += int'($signed(a[8*i +: 8])) * int'($signed(w[8*i +: 8]));
    return 25'(s);
  endfunction

  // PE model: three stall-gated register stages sharing rst_n with the sequencer.
  logic signed [24:0] s1, s2, s3, w1, w2, w3;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0; s2 <= '0; s3 <= '0;
    end else if (!pe_stall) begin
      s1 <= dot(ifm, wgt); s2 <= s1; s3 <= s2;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w1 <= '0; w2 <= '0; w3 <= '0;
    end else if (!pe_stall_w) begin
      w1 <= dot(ifm, wgt); w2 <= w1; w3 <= w2;
    end
  end
  assign pe_p_sum   = s3;
  assign pe_p_sum_w = w3;

  int     checks = 0;
  int     errors = 0;
  int     fire_cnt = 0, done_cnt = 0, fire_cnt_w = 0;
  int     f0, d0;
  longint sb[$];
  longint sb_exp;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor samples just after the negedge, when inputs and combinational outputs are settled.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (op_valid && op_ready) fire_cnt++;
      if (op_valid_w && op_ready_w) fire_cnt_w++;
      if (done) done_cnt++;
      if (acc_valid && acc_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0d with empty scoreboard", acc_out);
        end else begin
          sb_exp = sb.pop_front();
          check("acc_out", acc_out, sb_exp);
          check("acc_ovf", acc_ovf, 0);
        end
      end
    end
  end

  function automatic logic [31:0] val_ifm(input int v);
    return {24'd0, v[7:0]};
  endfunction

  task automatic start_job(input int len);
    @(negedge clk);
    start   = 1'b1;
    job_len = 8'(len);
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] w, input int gap);
    int t;
    @(negedge clk);
    ifm      = a;
    wgt      = w;
    op_valid = 1'b1;
    #1;
    t = 0;
    while (!op_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!op_ready) check("op_ready_timeout", op_ready, 1);
    repeat (gap) begin
      @(negedge clk);
      op_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int bound);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (!done && t < bound);
    check("done_seen", done, 1);
  endtask

  typedef struct {
    int len;
    int gap;
    int vals[4];
    int res;
  } job_t;

  job_t tbl[4];

  initial begin
    tbl[0] = '{len: 4, gap: 0, vals: '{10, -20, 30, -40}, res: -20};
    tbl[1] = '{len: 3, gap: 2, vals: '{7, 7, 7, 0},       res: 21};
    tbl[2] = '{len: 2, gap: 1, vals: '{127, -128, 0, 0},  res: -1};
    tbl[3] = '{len: 4, gap: 1, vals: '{-1, -1, -1, -1},   res: -4};

    rst_n = 1'b0;
    start = 1'b0; job_len = '0; op_valid = 1'b0; acc_ready = 1'b1;
    start_w = 1'b0; job_len_w = '0; op_valid_w = 1'b0; acc_ready_w = 1'b1;
    ifm = '0; wgt = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_op_ready", op_ready, 0);
    check("rst_pe_stall", pe_stall, 1);
    check("rst_acc_valid", acc_valid, 0);
    check("rst_acc_out", acc_out, 0);
    check("rst_acc_ovf", acc_ovf, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-length start is ignored.
    start_job(0);
    #1;
    check("len0_busy", busy, 0);
    check("len0_pe_stall", pe_stall, 1);

    // len=1 latency: start at edge S, result after S+4, done for one cycle.
    @(negedge clk);
    sb.push_back(10);
    ifm = {8'd4, 8'd3, 8'd2, 8'd1}; wgt = 32'h01010101;
    start = 1'b1; job_len = 8'd1; op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("t0_busy", busy, 1);
    check("t0_op_ready", op_ready, 1);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      check($sformatf("t%0d_acc_valid", k), acc_valid, (k == 4) ? 1 : 0);
      check($sformatf("t%0d_done", k), done, (k == 4) ? 1 : 0);
      check($sformatf("t%0d_busy", k), busy, (k < 4) ? 1 : 0);
    end

    // Table of jobs, all with acc_ready held high.
    for (int i = 0; i < 4; i++) begin
      sb.push_back(tbl[i].res);
      f0 = fire_cnt;
      d0 = done_cnt;
      start_job(tbl[i].len);
      for (int b = 0; b < tbl[i].len; b++)
        send_beat(val_ifm(tbl[i].vals[b]), 32'h1, tbl[i].gap);
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      check($sformatf("job%0d_op_ready_after_last", i), op_ready, 0);
      wait_done(60);
      repeat (3) @(negedge clk);
      #1;
      check($sformatf("job%0d_fires", i), fire_cnt - f0, tbl[i].len);
      check($sformatf("job%0d_dones", i), done_cnt - d0, 1);
    end

    // Backpressure: A's result held while B's last beat waits on the output register.
    @(negedge clk);
    acc_ready = 1'b0;
    sb.push_back(5);
    start_job(1);
    send_beat(val_ifm(5), 32'h1, 0);
    @(negedge clk);
    op_valid = 1'b0;
    wait_done(30);
    sb.push_back(7);
    start_job(2);
    send_beat(val_ifm(3), 32'h1, 0);
    send_beat(val_ifm(4), 32'h1, 0);
    @(negedge clk);
    op_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("bp_stall", pe_stall, 1);
    check("bp_busy", busy, 1);
    check("bp_held_out", acc_out, 5);
    repeat (2) @(negedge clk);
    #1;
    check("bp_stall_holds", pe_stall, 1);
    @(negedge clk);
    acc_ready = 1'b1;
    #1;
    check("bp_stall_released", pe_stall, 0);
    @(negedge clk);
    acc_ready = 1'b0;
    #1;
    check("bp_b_valid", acc_valid, 1);
    check("bp_b_out", acc_out, 7);
    check("bp_b_busy", busy, 0);
    check("bp_b_done", done, 1);
    @(negedge clk);
    acc_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Wide instance: 256 beats of 65536 overflow a 25-bit accumulator.
    @(negedge clk);
    ifm = 32'h80808080; wgt = 32'h80808080;
    start_w = 1'b1; job_len_w = 9'd256; op_valid_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;
    begin
      int t;
      t = 0;
      do begin
        @(negedge clk);
        #1;
        t++;
      end while (!done_w && t < 400);
    end
    check("wide_done_seen", done_w, 1);
    op_valid_w = 1'b0;
    check("wide_fires", fire_cnt_w, 256);
`ifdef PE_SEQ_SAT_EN
    check("wide_acc_out", acc_out_w, 16777215);
    check("wide_acc_ovf", acc_ovf_w, 1);
`else
    check("wide_acc_out", acc_out_w, -16777216);
    check("wide_acc_ovf", acc_ovf_w, 0);
`endif

    // Reset mid-job: len=4 with two beats fired, then a fresh len=1 job.
    start_job(4);
    send_beat(val_ifm(1), 32'h1, 0);
    send_beat(val_ifm(2), 32'h1, 0);
    @(negedge clk);
    op_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_op_ready", op_ready, 0);
    check("mid_rst_pe_stall", pe_stall, 1);
    check("mid_rst_acc_valid", acc_valid, 0);
    check("mid_rst_acc_out", acc_out, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_acc_ovf_w", acc_ovf_w, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(10);
    start_job(1);
    send_beat({8'd4, 8'd3, 8'd2, 8'd1}, 32'h01010101, 0);
    @(negedge clk);
    op_valid = 1'b0;
    wait_done(30);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_seq_ctrl.md
# pe_seq_ctrl

Job sequencer for one 4-lane PE MAC pipeline (3 registered stages: product, pair-sum, p_sum; all stages are gated by `stall`). It admits operand beats from an upstream stream and drives the PE stall. It tracks in-flight beats with a valid shift register and accumulates the per-beat `p_sum` results of a job into a wide accumulator. The final result is presented on a valid/ready output register, which lets the next job start while the previous result is still waiting.

## Interface
- `LEN_W`, 8: width of the job length and of the issue/retire counters.
- `ACC_W`, 32: accumulator/result width. Must be ≥ 25.

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  job request, sampled only in IDLE
- `job_len`  in  LEN_W  number of 4-lane beats in the job. 0 means `start` is ignored.
- `busy`  out  1  high in RUN
- `op_valid`  in  1  upstream operand beat valid. Operand data is wired directly to the PE inputs.
- `op_ready`  out  1  beat accepted on `op_valid && op_ready`
- `pe_stall`  out  1  drives the PE `stall`
- `pe_p_sum`  in  25  signed PE result
- `acc_out`  out  ACC_W  signed job result
- `acc_valid`  out  1  result register full
- `acc_ready`  in  1  downstream accept
- `acc_ovf`  out  1  result saturated (see Configuration)
- `done`  out  1  one-cycle pulse, the cycle after a job's last retire

## Operation
- States: IDLE, RUN.
- IDLE → RUN on `start && job_len != 0`.
  - Latch `job_len`.
  - Clear the issue and retire counters and the accumulator.
  - `start` is ignored in RUN.
- Fire = `op_valid && op_ready`.
- `op_ready` = RUN && issued < len && !`pe_stall`.
- Valid shift register `vld[2:0]`: when !`pe_stall`, `vld <= {vld[1:0], fire}`. When stalled, `vld` holds.
- Retire = `vld[2] && !pe_stall`. `pe_p_sum` is valid in any cycle with `vld[2]` high.
- On retire:
  - Sign-extend `pe_p_sum` to ACC_W.
  - First retire of a job: acc ← value. Later retires: acc ← acc + value.
  - Increment the retire counter.
- Last retire (retire counter = len−1):
  - Write the final sum to `acc_out`/`acc_ovf` and set `acc_valid`.
  - RUN → IDLE.
  - `done` pulses in the next cycle.
- `acc_valid` clears on `acc_valid && acc_ready`.
- `pe_stall` (combinational) = IDLE || (`vld[2]` && last retire pending && `acc_valid` && !`acc_ready`).
  - A full output register accepted in the same cycle is not a stall; the write replaces the result.
- Counters are LEN_W bits; no wrap within a job because issued ≤ len.
- Arithmetic: two's complement, modulo 2^ACC_W unless `PE_SEQ_SAT_EN` is defined.

## Timing
- Reset values:
  - FSM = IDLE.
  - `busy`=0, `op_ready`=0, `pe_stall`=1.
  - `vld`=0, counters=0.
  - `acc_out`=0, `acc_valid`=0, `acc_ovf`=0, `done`=0.
- Reset mid-job aborts immediately. The PE shares `rst_n`, so no stale in-flight data survives.
- `start` accepted at edge S: `op_ready` can first be high in the cycle after S.
- Beat fired at edge E: `vld[2]` is high after E+2 (unstalled) and the beat retires at E+3.
- Job of len beats, fired back-to-back from edge S+1 with no stall:
  - `acc_valid` rises after edge S+len+3.
  - `busy` falls at the same edge.
  - `done` is high for the following cycle.
- Bubbles (`op_valid` low) advance the pipeline with `vld` = 0. Stall cycles freeze both the pipeline and `vld`.
- No overlap of two jobs inside the PE. Overlap exists only between a pending result and the next job's RUN.

## Configuration
- `PE_SEQ_SAT_EN` defined:
  - Each accumulate saturates to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - Any saturation in a job sets `acc_ovf` with that job's result.
- Not defined:
  - The accumulator wraps.
  - `acc_ovf` is constant 0.

## Test plan
- len=1, ifm=(1,2,3,4), wgt=(1,1,1,1), `start` at edge S, `op_valid` held, `acc_ready`=1 → `acc_out`=10, `acc_valid` after edge S+4, single `done` pulse.
- len=4, beats with p_sum 10, −20, 30, −40, back-to-back → `acc_out`=−20, exactly 4 fires, `op_ready` low after the 4th.
- len=3 with 2-cycle `op_valid` gaps, p_sum 7 each → `acc_out`=21, retires on correct cycles, no extra fires.
- Backpressure, `acc_ready`=0:
  - Job A (len=1, result 5) is held.
  - Job B (len=2, p_sum 3, 4) starts.
  - `pe_stall`=1 while B's last beat waits.
  - One-cycle `acc_ready` → A's 5 accepted, B's 7 appears, `pe_stall` drops.
- Overrides LEN_W=9, ACC_W=25; len=256, all ifm/wgt = −128 (p_sum 65536) → with macro: 16777215 and `acc_ovf`=1; without macro: −16777216 and `acc_ovf`=0.
- `rst_n` low mid-RUN (job len=4, 2 beats fired) → all outputs at reset values. A following len=1 job with ifm=(1,2,3,4), wgt=(1,1,1,1) returns 10.
